// File: rtl/phase_sequencer.sv
// Four-phase instruction sequencer: a one-hot phase ring that drives the microinstruction
// decoder, plus the instruction register and program counter that the decoder updates.
module phase_sequencer (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic step,
  input  logic instr_in0,
  input  logic instr_in1,
  input  logic instr_in2,
  input  logic instr_in3,
  input  logic load_instr,
  input  logic prog_count,
  output logic phase0,
  output logic phase1,
  output logic phase2,
  output logic phase3,
  output logic instr0,
  output logic instr1,
  output logic instr2,
  output logic instr3,
  output logic pc0,
  output logic pc1,
  output logic pc2,
  output logic pc3,
  output logic running,
  output logic halted
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_t;

  localparam logic [3:0] PH_NONE  = 4'b0000;
  localparam logic [3:0] PH_FIRST = 4'b0001;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  state_t     state;
  logic [3:0] phase;
  logic [3:0] instr;
  logic [3:0] pc;
  logic [3:0] instr_in;

  assign instr_in = {instr_in3, instr_in2, instr_in1, instr_in0};

  // NOTE: every register below uses non-blocking assignments so all of them
  // update together from the values held before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= PH_NONE;
      instr   <= 4'b0000;
      pc      <= 4'b0000;
      running <= 1'b0;
      halted  <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (run || step) begin
            state   <= run ? RUN : STEP;
            phase   <= PH_FIRST;
            running <= 1'b1;
            halted  <= 1'b0;
          end
        end
        RUN, STEP: begin
          if (load_instr) instr <= instr_in;
          if (prog_count) pc <= pc + 4'd1;
          // The halt test reads the instruction held before this edge.
          if (!$onehot(phase)) begin
            phase <= PH_FIRST;
          end else if (phase[3]) begin
            if (instr == OP_HALT) begin
              state   <= HALT;
              phase   <= PH_NONE;
              running <= 1'b0;
              halted  <= 1'b1;
            end else if (state == STEP || !run) begin
              state   <= IDLE;
              phase   <= PH_NONE;
              running <= 1'b0;
            end else begin
              phase <= PH_FIRST;
            end
          end else begin
            phase <= {phase[2:0], 1'b0};
          end
        end
        default: begin
          state   <= IDLE;
          phase   <= PH_NONE;
          running <= 1'b0;
          halted  <= 1'b0;
        end
      endcase
    end
  end

  assign {phase3, phase2, phase1, phase0} = phase;
  assign {instr3, instr2, instr1, instr0} = instr;
  assign {pc3, pc2, pc1, pc0}             = pc;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: the driver queues the expected post-edge outputs
// for each cycle, and an independent monitor compares them one cycle at a time.
module tb_phase_sequencer;

  typedef struct {
    logic [3:0] phase;
    logic [3:0] instr;
    logic [3:0] pc;
    logic       running;
    logic       halted;
  } exp_t;

  localparam logic [3:0] PZ = 4'b0000;
  localparam logic [3:0] P0 = 4'b0001;
  localparam logic [3:0] P1 = 4'b0010;
  localparam logic [3:0] P2 = 4'b0100;
  localparam logic [3:0] P3 = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       run, step, load_instr, prog_count;
  logic [3:0] ii;
  logic       phase0, phase1, phase2, phase3;
  logic       instr0, instr1, instr2, instr3;
  logic       pc0, pc1, pc2, pc3;
  logic       running, halted;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  phase_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .instr_in0(ii[0]), .instr_in1(ii[1]), .instr_in2(ii[2]), .instr_in3(ii[3]),
    .load_instr(load_instr), .prog_count(prog_count),
    .phase0(phase0), .phase1(phase1), .phase2(phase2), .phase3(phase3),
    .instr0(instr0), .instr1(instr1), .instr2(instr2), .instr3(instr3),
    .pc0(pc0), .pc1(pc1), .pc2(pc2), .pc3(pc3),
    .running(running), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, " phase"},   {phase3, phase2, phase1, phase0}, e.phase);
    check({tag, " instr"},   {instr3, instr2, instr1, instr0}, e.instr);
    check({tag, " pc"},      {pc3, pc2, pc1, pc0},             e.pc);
    check({tag, " running"}, {3'b000, running},                {3'b000, e.running});
    check({tag, " halted"},  {3'b000, halted},                 {3'b000, e.halted});
  endtask

  // Drive one cycle's inputs and queue the outputs expected after the next rising edge.
  task automatic cyc(input logic r, input logic s, input logic ld, input logic inc,
                     input logic [3:0] din, input logic [3:0] ph, input logic [3:0] ins,
                     input logic [3:0] p, input logic rn, input logic h);
    @(negedge clk);
    run = r; step = s; load_instr = ld; prog_count = inc; ii = din;
    sb.push_back('{phase: ph, instr: ins, pc: p, running: rn, halted: h});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_all("cycle", e);
      end
    end
  end

  initial begin : driver
    logic [3:0] ph;
    logic [3:0] p;
    rst = 1'b1; run = 1'b0; step = 1'b0; load_instr = 1'b0; prog_count = 1'b0; ii = 4'h0;
    #1;
    check_all("reset", '{phase: PZ, instr: 4'h0, pc: 4'h0, running: 1'b0, halted: 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Continuous run with a ProgCount pulse in Phase1.
    cyc(1,0,0,0,4'h0, P0,4'h0,4'h0,1,0);
    cyc(1,0,0,0,4'h0, P1,4'h0,4'h0,1,0);
    cyc(1,0,0,1,4'h0, P2,4'h0,4'h1,1,0);
    cyc(1,0,0,0,4'h0, P3,4'h0,4'h1,1,0);
    cyc(1,0,0,0,4'h0, P0,4'h0,4'h1,1,0);
    // Run dropped during Phase1: instruction still completes.
    cyc(1,0,0,0,4'h0, P1,4'h0,4'h1,1,0);
    cyc(0,0,0,0,4'h0, P2,4'h0,4'h1,1,0);
    cyc(0,0,0,0,4'h0, P3,4'h0,4'h1,1,0);
    cyc(0,0,0,0,4'h0, PZ,4'h0,4'h1,0,0);
    cyc(0,0,1,1,4'h9, PZ,4'h0,4'h1,0,0);

    // Single step.
    cyc(0,1,0,0,4'h0, P0,4'h0,4'h1,1,0);
    cyc(0,0,0,1,4'h0, P1,4'h0,4'h2,1,0);
    cyc(0,0,0,0,4'h0, P2,4'h0,4'h2,1,0);
    cyc(0,0,0,0,4'h0, P3,4'h0,4'h2,1,0);
    cyc(0,0,0,0,4'h0, PZ,4'h0,4'h2,0,0);
    cyc(0,0,0,0,4'h0, PZ,4'h0,4'h2,0,0);

    // Halt opcode in RUN, hold in HALT, resume.
    cyc(1,0,0,0,4'h0, P0,4'h0,4'h2,1,0);
    cyc(1,0,1,0,4'hF, P1,4'hF,4'h2,1,0);
    cyc(1,0,0,0,4'h0, P2,4'hF,4'h2,1,0);
    cyc(1,0,0,0,4'h0, P3,4'hF,4'h2,1,0);
    cyc(1,0,0,0,4'h0, PZ,4'hF,4'h2,0,1);
    cyc(0,0,1,1,4'h3, PZ,4'hF,4'h2,0,1);
    cyc(1,0,0,0,4'h0, P0,4'hF,4'h2,1,0);
    cyc(1,0,1,0,4'h3, P1,4'h3,4'h2,1,0);
    cyc(1,0,0,0,4'h0, P2,4'h3,4'h2,1,0);
    cyc(1,0,0,0,4'h0, P3,4'h3,4'h2,1,0);
    // 1111 loaded on the Phase3 edge must not halt this instruction.
    cyc(0,0,1,0,4'hF, PZ,4'hF,4'h2,0,0);
    // Halt from STEP.
    cyc(0,1,0,0,4'h0, P0,4'hF,4'h2,1,0);
    cyc(0,0,0,0,4'h0, P1,4'hF,4'h2,1,0);
    cyc(0,0,0,0,4'h0, P2,4'hF,4'h2,1,0);
    cyc(0,0,0,0,4'h0, P3,4'hF,4'h2,1,0);
    cyc(0,0,0,0,4'h0, PZ,4'hF,4'h2,0,1);
    cyc(0,1,0,0,4'h0, P0,4'hF,4'h2,1,0);
    cyc(0,0,1,0,4'h0, P1,4'h0,4'h2,1,0);
    cyc(0,0,0,0,4'h0, P2,4'h0,4'h2,1,0);
    cyc(0,0,0,0,4'h0, P3,4'h0,4'h2,1,0);
    cyc(0,0,0,0,4'h0, PZ,4'h0,4'h2,0,0);

    // PC counts up through 1111 and wraps to 0000.
    cyc(1,0,0,0,4'h0, P0,4'h0,4'h2,1,0);
    for (int k = 1; k <= 14; k++) begin
      ph = P0 << (k % 4);
      p  = 4'd2 + 4'(k);
      cyc(1,0,0,1,4'h0, ph,4'h0,p,1,0);
    end
    cyc(1,0,0,0,4'h0, P3,4'h0,4'h0,1,0);
    cyc(0,0,0,0,4'h0, PZ,4'h0,4'h0,0,0);

    // Run and Step together: RUN wins and rotates past Phase3.
    cyc(1,1,0,0,4'h0, P0,4'h0,4'h0,1,0);
    cyc(1,1,1,1,4'h5, P1,4'h5,4'h1,1,0);
    cyc(1,1,0,0,4'h0, P2,4'h5,4'h1,1,0);
    cyc(1,1,0,0,4'h0, P3,4'h5,4'h1,1,0);
    cyc(1,1,0,0,4'h0, P0,4'h5,4'h1,1,0);
    cyc(1,1,0,0,4'h0, P1,4'h5,4'h1,1,0);
    cyc(1,0,0,0,4'h0, P2,4'h5,4'h1,1,0);

    // Asynchronous reset in Phase2, checked before any further edge.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all("async reset", '{phase: PZ, instr: 4'h0, pc: 4'h0, running: 1'b0, halted: 1'b0});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{phase: P0, instr: 4'h0, pc: 4'h0, running: 1'b1, halted: 1'b0});
    cyc(1,0,0,0,4'h0, P1,4'h0,4'h0,1,0);
    cyc(0,0,0,0,4'h0, P2,4'h0,4'h0,1,0);
    cyc(0,0,0,0,4'h0, P3,4'h0,4'h0,1,0);
    cyc(0,0,0,0,4'h0, PZ,4'h0,4'h0,0,0);

    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #2;
    end
    check("scoreboard drained", 4'(sb.size()), 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
